// File: rtl/mod_arith_pkg.sv
// Shared definitions for the modular arithmetic datapath blocks (add/sub today, multipliers later).
// Holds the op encoding and the legality check for a (WIDTH, MODULUS) pair.
package mod_arith_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Upper width bound keeps 2^width representable in a longint.
  function automatic bit mod_params_ok(input int width, input longint modulus);
    return (width >= 2) && (width <= 62) &&
           (modulus >= 2) && (modulus <= (longint'(1) << width));
  endfunction

endpackage

// File: rtl/mod_addsub_pipe_if.sv
// Operand/result handshake bundle for mod_addsub_pipe.
// master drives operands and out_ready; slave is the pipeline itself.
interface mod_addsub_pipe_if #(
  parameter int WIDTH = 4
);
  logic             s;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] z;
  logic             err;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output s, x, y, in_valid, out_ready,
    input  in_ready, z, err, out_valid
  );

  modport slave (
    input  s, x, y, in_valid, out_ready,
    output in_ready, z, err, out_valid
  );
endinterface

// File: rtl/mod_pipe_slot.sv
// Single valid/ready register slot carrying a DW-bit payload.
// Latency: 1 cycle. Backpressure: accepts when empty or when downstream takes the held word.
// Held payload stays stable while out_vld is high and out_rdy is low.
module mod_pipe_slot #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] in_dat,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_dat
);

  assign in_rdy = !out_vld || out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (in_rdy) begin
      out_vld <= in_vld;
      if (in_vld) begin
        out_dat <= in_dat;
      end
    end
  end

endmodule

// File: rtl/mod_addsub_pipe.sv
// Modular add/subtract z = (x +/- y) mod MODULUS; MOD_ADDSUB_RANGE_CHECK_EN adds an operand range flag on err.
// Latency: 3 cycles accept-to-out_valid, one result per cycle when unstalled.
// Backpressure: three valid/ready slots, bubbles collapse; in_ready is combinational from out_ready only.
module mod_addsub_pipe
  import mod_arith_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 15
) (
  input logic              clk,
  input logic              rst_n,
  mod_addsub_pipe_if.slave io
);

  if (!mod_params_ok(WIDTH, MODULUS)) begin : g_bad_params
    $fatal(1, "mod_addsub_pipe: illegal WIDTH/MODULUS pair");
  end

  localparam logic [WIDTH:0]   M_T = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH+1:0] M_C = (WIDTH+2)'(MODULUS);

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
  localparam int FW = 1;
`else
  localparam int FW = 0;
`endif

  localparam int P1 = 1 + (WIDTH + 1) + FW;
  localparam int P2 = 1 + (WIDTH + 1) + (WIDTH + 2) + FW;
  localparam int P3 = WIDTH + FW;

  logic          v1, v2, v3;
  logic          rdy2, rdy3;
  logic [P1-1:0] d1_in, d1;
  logic [P2-1:0] d2_in, d2;
  logic [P3-1:0] d3_in, d3;

  // Stage 1: raw sum, or difference whose top bit is the borrow.
  logic [WIDTH:0] t_in;

  always_comb begin
    if (io.s == OP_SUB) begin
      t_in = {1'b0, io.x} - {1'b0, io.y};
    end else begin
      t_in = {1'b0, io.x} + {1'b0, io.y};
    end
  end

  // Stage 2: correction candidate, one extra bit so t + M cannot wrap.
  logic             op1;
  logic [WIDTH:0]   t1;
  logic [WIDTH+1:0] c_in;

  always_comb begin
    if (op1 == OP_SUB) begin
      c_in = {1'b0, t1} + M_C;
    end else begin
      c_in = {1'b0, t1} - M_C;
    end
  end

  // Stage 3: pick corrected or raw value; M = 2^WIDTH reduces to carry-out.
  logic             op2;
  logic [WIDTH:0]   t2;
  logic [WIDTH+1:0] c2;
  logic             take_c;
  logic [WIDTH-1:0] z_in;
  logic [WIDTH-1:0] z3;

  always_comb begin
    if (op2 == OP_SUB) begin
      take_c = t2[WIDTH];
    end else begin
      take_c = (t2 >= M_T);
    end
    z_in = WIDTH'(take_c ? c2 : {1'b0, t2});
  end

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
  logic f_in, f1, f2, f3;

  assign f_in        = ({1'b0, io.x} >= M_T) || ({1'b0, io.y} >= M_T);
  assign d1_in       = {io.s, t_in, f_in};
  assign {op1, t1, f1} = d1;
  assign d2_in       = {op1, t1, c_in, f1};
  assign {op2, t2, c2, f2} = d2;
  assign d3_in       = {z_in, f2};
  assign {z3, f3}    = d3;
  assign io.err      = f3;
`else
  assign d1_in       = {io.s, t_in};
  assign {op1, t1}   = d1;
  assign d2_in       = {op1, t1, c_in};
  assign {op2, t2, c2} = d2;
  assign d3_in       = z_in;
  assign z3          = d3;
  assign io.err      = 1'b0;
`endif

  mod_pipe_slot #(.DW(P1)) u_slot1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (io.in_valid),
    .in_rdy  (io.in_ready),
    .in_dat  (d1_in),
    .out_vld (v1),
    .out_rdy (rdy2),
    .out_dat (d1)
  );

  mod_pipe_slot #(.DW(P2)) u_slot2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (v1),
    .in_rdy  (rdy2),
    .in_dat  (d2_in),
    .out_vld (v2),
    .out_rdy (rdy3),
    .out_dat (d2)
  );

  mod_pipe_slot #(.DW(P3)) u_slot3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (v2),
    .in_rdy  (rdy3),
    .in_dat  (d3_in),
    .out_vld (v3),
    .out_rdy (io.out_ready),
    .out_dat (d3)
  );

  assign io.z         = z3;
  assign io.out_valid = v3;

endmodule
